// File: rtl/uart_rx_frame_ctrl.sv
// UART packet framer: hunts HDR, takes LEN, buffers payload, verifies the
// XOR checksum and streams the payload out on a valid/ready port.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ctrl_en                   block enable; low drops any partial frame
//   rx_en_sig                 enable to the byte receiver (ctrl_en delayed)
//   rx_done, rx_data          byte strobe and byte from the receiver
//   m_data, m_valid, m_last   payload stream out
//   m_ready                   downstream accept
//   pkt_ok                    pulse when the last byte is accepted
//   err_csum, err_len         checksum / length error pulses
//   err_timeout, overrun      inter-byte timeout / byte dropped in SEND
//   pkt_cnt                   good packets delivered (wraps)
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  HDR     = 8'hAA,
  parameter int          MAX_LEN = 16,
  parameter logic [15:0] TIMEOUT = 16'd4340
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_en,
  output logic        rx_en_sig,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        pkt_ok,
  output logic        err_csum,
  output logic        err_len,
  output logic        err_timeout,
  output logic        overrun,
  output logic [15:0] pkt_cnt
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [LW-1:0] ONE = LW'(1);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CSUM    = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;

  logic [2:0]    state;
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [LW-1:0] rd_idx;
  logic [LW-1:0] rd_nxt;
  logic [7:0]    csum_acc;
  logic [15:0]   tmo_cnt;
  logic [7:0]    pay_mem [MAX_LEN];
  logic          timing;
  logic          tmo_hit;
  logic          len_bad;

  assign timing  = (state == S_LEN) || (state == S_PAYLOAD) ||
                   (state == S_CSUM);
  // A byte arriving on the expiry cycle takes precedence.
  assign tmo_hit = timing && !rx_done &&
                   (tmo_cnt == TIMEOUT - 16'd1);
  assign len_bad = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));
  assign rd_nxt  = rd_idx + ONE;

  always_ff @(posedge clk) begin
    if (!rst && ctrl_en && state == S_PAYLOAD && rx_done)
      pay_mem[idx[IW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HUNT;
      rx_en_sig   <= 1'b0;
      m_data      <= 8'd0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      pkt_ok      <= 1'b0;
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
      pkt_cnt     <= 16'd0;
      len         <= '0;
      idx         <= '0;
      rd_idx      <= '0;
      csum_acc    <= 8'd0;
      tmo_cnt     <= 16'd0;
    end else begin
      rx_en_sig   <= ctrl_en;
      pkt_ok      <= 1'b0;
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
      if (!ctrl_en) begin
        state   <= S_HUNT;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        tmo_cnt <= 16'd0;
      end else begin
        // Runs only while mid-frame; any byte restarts it.
        tmo_cnt <= (timing && !rx_done) ? tmo_cnt + 16'd1 : 16'd0;
        if (tmo_hit) begin
          err_timeout <= 1'b1;
          state       <= S_HUNT;
          tmo_cnt     <= 16'd0;
        end else begin
          unique case (state)
            S_HUNT: begin
              if (rx_done && rx_data == HDR)
                state <= S_LEN;
            end
            S_LEN: begin
              if (rx_done) begin
                len      <= rx_data[LW-1:0];
                csum_acc <= rx_data;
                idx      <= '0;
                if (len_bad) begin
                  err_len <= 1'b1;
                  state   <= S_HUNT;
                end else begin
                  state <= S_PAYLOAD;
                end
              end
            end
            S_PAYLOAD: begin
              if (rx_done) begin
                csum_acc <= csum_acc ^ rx_data;
                idx      <= idx + ONE;
                if (idx == len - ONE)
                  state <= S_CSUM;
              end
            end
            S_CSUM: begin
              if (rx_done) begin
                if (rx_data == csum_acc) begin
                  rd_idx  <= '0;
                  m_data  <= pay_mem[0];
                  m_valid <= 1'b1;
                  m_last  <= (len == ONE);
                  state   <= S_SEND;
                end else begin
                  err_csum <= 1'b1;
                  state    <= S_HUNT;
                end
              end
            end
            S_SEND: begin
              if (rx_done)
                overrun <= 1'b1;
              if (m_valid && m_ready) begin
                if (m_last) begin
                  pkt_ok  <= 1'b1;
                  pkt_cnt <= pkt_cnt + 16'd1;
                  m_valid <= 1'b0;
                  m_last  <= 1'b0;
                  state   <= S_HUNT;
                end else begin
                  rd_idx <= rd_nxt;
                  m_data <= pay_mem[rd_nxt[IW-1:0]];
                  m_last <= (rd_nxt == len - ONE);
                end
              end
            end
            default: state <= S_HUNT;
          endcase
        end
      end
    end
  end

endmodule
